// File: rtl/spi_lcd_cmd_decoder.sv
// ============================================================================
// spi_lcd_cmd_decoder
// ST7735-style command/parameter decoder feeding the SRAM frame-buffer writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_lcd_cmd_decoder #(
    parameter int unsigned PULSE_LEN  = 4,
    parameter logic [7:0]  PWM_RST    = 8'd255,
    parameter logic [7:0]  COLMOD_RST = 8'h05
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_spi_data,
    input  logic        i_spi_dc,
    input  logic        i_spi_rxdone,
    output logic [15:0] o_pixel_data,
    output logic [31:0] o_col_addr,
    output logic [31:0] o_row_addr,
    output logic [7:0]  o_madctl,
    output logic [7:0]  o_colmod,
    output logic [7:0]  o_pwm_duty,
    output logic        o_dispOn,
    output logic        o_sram_clr_req,
    output logic        o_sram_write_req,
    output logic        o_sram_waddr_set_req
);

    localparam logic [7:0] c_CMD_NOP     = 8'h00;
    localparam logic [7:0] c_CMD_SWRESET = 8'h01;
    localparam logic [7:0] c_CMD_PWMDS   = 8'h02;
    localparam logic [7:0] c_CMD_DISPOFF = 8'h28;
    localparam logic [7:0] c_CMD_DISPON  = 8'h29;
    localparam logic [7:0] c_CMD_CASET   = 8'h2A;
    localparam logic [7:0] c_CMD_RASET   = 8'h2B;
    localparam logic [7:0] c_CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] c_CMD_MADCTL  = 8'h36;
    localparam logic [7:0] c_CMD_COLMOD  = 8'h3A;

    logic [7:0]  cmd_q,    cmd_d;
    logic [2:0]  pcnt_q,   pcnt_d;
    logic [1:0]  phase_q,  phase_d;
    logic [10:0] stage_q,  stage_d;
    logic [15:0] pixel_q,  pixel_d;
    logic [31:0] col_q,    col_d;
    logic [31:0] row_q,    row_d;
    logic [7:0]  madctl_q, madctl_d;
    logic [7:0]  colmod_q, colmod_d;
    logic [7:0]  pwm_q,    pwm_d;
    logic        disp_q,   disp_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]  wr_cnt_q,  wr_cnt_d;
    logic [3:0]  wa_cnt_q,  wa_cnt_d;

    logic       w_clr_trig;
    logic       w_wr_trig;
    logic       w_wa_trig;
    logic [2:0] w_pcnt_inc;

    // A trigger reloads the full width, so a retrigger extends the pulse gap-free.
    function automatic logic [3:0] pulse_next(input logic trig, input logic [3:0] cnt);
        if (trig)
            return 4'(PULSE_LEN);
        else if (cnt != 4'd0)
            return cnt - 4'd1;
        return 4'd0;
    endfunction

    assign w_pcnt_inc = (pcnt_q < 3'd4) ? pcnt_q + 3'd1 : pcnt_q;

    always_comb begin
        cmd_d      = cmd_q;
        pcnt_d     = pcnt_q;
        phase_d    = phase_q;
        stage_d    = stage_q;
        pixel_d    = pixel_q;
        col_d      = col_q;
        row_d      = row_q;
        madctl_d   = madctl_q;
        colmod_d   = colmod_q;
        pwm_d      = pwm_q;
        disp_d     = disp_q;
        w_clr_trig = 1'b0;
        w_wr_trig  = 1'b0;
        w_wa_trig  = 1'b0;

        if (i_spi_rxdone && !i_spi_dc) begin
            cmd_d   = i_spi_data;
            pcnt_d  = 3'd0;
            phase_d = 2'd0;
            case (i_spi_data)
                c_CMD_SWRESET: begin
                    pwm_d      = PWM_RST;
                    colmod_d   = COLMOD_RST;
                    madctl_d   = 8'h00;
                    disp_d     = 1'b0;
                    w_clr_trig = 1'b1;
                end
                c_CMD_DISPOFF: disp_d    = 1'b0;
                c_CMD_DISPON:  disp_d    = 1'b1;
                c_CMD_RAMWR:   w_wa_trig = 1'b1;
                default: ;
            endcase
        end else if (i_spi_rxdone) begin
            pcnt_d = w_pcnt_inc;
            case (cmd_q)
                c_CMD_CASET: if (pcnt_q < 3'd4) begin
                    col_d     = {col_q[23:0], i_spi_data};
                    w_wa_trig = (pcnt_q == 3'd3);
                end
                c_CMD_RASET: if (pcnt_q < 3'd4) begin
                    row_d     = {row_q[23:0], i_spi_data};
                    w_wa_trig = (pcnt_q == 3'd3);
                end
                c_CMD_PWMDS:  pwm_d = i_spi_data;
                c_CMD_MADCTL: if (pcnt_q == 3'd0) madctl_d = i_spi_data;
                c_CMD_COLMOD: if (pcnt_q == 3'd0 &&
                                  (i_spi_data[2:0] == 3'd5 || i_spi_data[2:0] == 3'd6))
                    colmod_d = i_spi_data;
                c_CMD_RAMWR: begin
                    // Staging holds R[7:3],G[7:2] (18 bpp) or the high byte (16 bpp).
                    if (colmod_q[2:0] == 3'd6) begin
                        case (phase_q)
                            2'd0: begin
                                stage_d = {i_spi_data[7:3], 6'd0};
                                phase_d = 2'd1;
                            end
                            2'd1: begin
                                stage_d = {stage_q[10:6], i_spi_data[7:2]};
                                phase_d = 2'd2;
                            end
                            default: begin
                                pixel_d   = {stage_q, i_spi_data[7:3]};
                                w_wr_trig = 1'b1;
                                phase_d   = 2'd0;
                            end
                        endcase
                    end else begin
                        if (phase_q == 2'd0) begin
                            stage_d = {i_spi_data, 3'd0};
                            phase_d = 2'd1;
                        end else begin
                            pixel_d   = {stage_q[10:3], i_spi_data};
                            w_wr_trig = 1'b1;
                            phase_d   = 2'd0;
                        end
                    end
                end
                c_CMD_NOP: ;
                default: ;
            endcase
        end

        clr_cnt_d = pulse_next(w_clr_trig, clr_cnt_q);
        wr_cnt_d  = pulse_next(w_wr_trig,  wr_cnt_q);
        wa_cnt_d  = pulse_next(w_wa_trig,  wa_cnt_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q     <= c_CMD_NOP;
            pcnt_q    <= 3'd0;
            phase_q   <= 2'd0;
            stage_q   <= 11'd0;
            pixel_q   <= 16'd0;
            col_q     <= 32'd0;
            row_q     <= 32'd0;
            madctl_q  <= 8'h00;
            colmod_q  <= COLMOD_RST;
            pwm_q     <= PWM_RST;
            disp_q    <= 1'b0;
            clr_cnt_q <= 4'd0;
            wr_cnt_q  <= 4'd0;
            wa_cnt_q  <= 4'd0;
        end else begin
            cmd_q     <= cmd_d;
            pcnt_q    <= pcnt_d;
            phase_q   <= phase_d;
            stage_q   <= stage_d;
            pixel_q   <= pixel_d;
            col_q     <= col_d;
            row_q     <= row_d;
            madctl_q  <= madctl_d;
            colmod_q  <= colmod_d;
            pwm_q     <= pwm_d;
            disp_q    <= disp_d;
            clr_cnt_q <= clr_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wa_cnt_q  <= wa_cnt_d;
        end
    end

    assign o_pixel_data         = pixel_q;
    assign o_col_addr           = col_q;
    assign o_row_addr           = row_q;
    assign o_madctl             = madctl_q;
    assign o_colmod             = colmod_q;
    assign o_pwm_duty           = pwm_q;
    assign o_dispOn             = disp_q;
    assign o_sram_clr_req       = (clr_cnt_q != 4'd0);
    assign o_sram_write_req     = (wr_cnt_q  != 4'd0);
    assign o_sram_waddr_set_req = (wa_cnt_q  != 4'd0);

endmodule

`default_nettype wire
